// File: rtl/cpu_mem_pkg.sv
// ---------------------------------------------------------------------------
// cpu_mem_pkg
//   Shared constants for the memory-to-datapath glue in the CPU top level.
//   - MODE_BYPASS / MODE_REGISTERED select how stall_hold_buffer presents data.
//   - NOP_INSTR is the MIPS NOP encoding (sll $0,$0,0) used as the default
//     squash value for flushed instruction channels.
// ---------------------------------------------------------------------------
package cpu_mem_pkg;

    // Output presentation modes of stall_hold_buffer.
    localparam int MODE_BYPASS     = 0;  // live data when not stalled, held data when stalled
    localparam int MODE_REGISTERED = 1;  // always held data, one cycle of latency

    // sll $0,$0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Next value of a saturating up-counter with a synchronous clear.
    // Clear wins over increment; at all-ones the counter stays pinned.
    function automatic logic [63:0] sat_next(input logic [63:0] cur,
                                             input logic [63:0] max_val,
                                             input logic        clr,
                                             input logic        inc);
        logic [63:0] nxt;
        nxt = cur;
        if (clr) begin
            nxt = '0;
        end else if (inc && (cur != max_val)) begin
            nxt = cur + 64'd1;
        end
        return nxt;
    endfunction

endpackage : cpu_mem_pkg

// File: rtl/stall_hold_buffer_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   W-bit saturating up-counter with synchronous clear.
//   Ports:
//     clk  in   1  clock
//     rst  in   1  asynchronous reset, active-high (counter -> 0)
//     clr  in   1  synchronous clear; takes priority over inc
//     inc  in   1  count enable; ignored once the counter is all-ones
//     q    out  W  current count
// ---------------------------------------------------------------------------
module sat_counter
    import cpu_mem_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // The helper works on 64-bit values so one function serves every width;
    // only the low W bits are meaningful here.
    logic [63:0] cur_ext;
    logic [63:0] max_ext;
    logic [63:0] nxt_ext;

    always_comb begin
        cur_ext        = '0;
        max_ext        = '0;
        cur_ext[W-1:0] = cnt_q;
        max_ext[W-1:0] = '1;
        nxt_ext        = sat_next(cur_ext, max_ext, clr, inc);
        cnt_d          = nxt_ext[W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule : sat_counter

// File: rtl/stall_hold_buffer.sv
// ---------------------------------------------------------------------------
// stall_hold_buffer
//   Stall-tolerant capture of synchronous-memory read data. Each of CHANNELS
//   channels keeps the last value captured while the pipeline was running and
//   presents it while the memory system stalls. Masked channels can be
//   flushed to FLUSH_VAL. Two saturating counters report stall statistics.
//
//   Parameters:
//     CHANNELS    number of independent channels (>=1)
//     WIDTH       bits per channel
//     MODE        MODE_BYPASS or MODE_REGISTERED (see cpu_mem_pkg)
//     RESET_VAL   hold register value after reset
//     FLUSH_VAL   value loaded into a flushed channel
//     FLUSH_MASK  bit c = 1: channel c responds to flush
//     CNT_W       statistics counter width
//
//   Ports:
//     clk           in   1               system clock
//     rst           in   1               asynchronous reset, active-high
//     stall         in   1               memory stall; freezes hold registers
//     flush         in   1               squash held/incoming data on masked channels
//     clr_stats     in   1               synchronous clear of both counters
//     live_in       in   CHANNELS*WIDTH  raw memory outputs, channel c = [c*WIDTH +: WIDTH]
//     data_out      out  CHANNELS*WIDTH  stall-safe data to the datapath
//     hold_active   out  1               stall registered: hold regs were frozen last cycle
//     stall_cycles  out  CNT_W           saturating count of stalled cycles
//     stall_events  out  CNT_W           saturating count of stall rising edges
// ---------------------------------------------------------------------------
module stall_hold_buffer
    import cpu_mem_pkg::*;
#(
    parameter int                     CHANNELS   = 2,
    parameter int                     WIDTH      = 32,
    parameter int                     MODE       = MODE_BYPASS,
    parameter logic [WIDTH-1:0]       RESET_VAL  = '0,
    parameter logic [WIDTH-1:0]       FLUSH_VAL  = WIDTH'(NOP_INSTR),
    parameter logic [CHANNELS-1:0]    FLUSH_MASK = '1,
    parameter int                     CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stall,
    input  logic                        flush,
    input  logic                        clr_stats,
    input  logic [CHANNELS*WIDTH-1:0]   live_in,
    output logic [CHANNELS*WIDTH-1:0]   data_out,
    output logic                        hold_active,
    output logic [CNT_W-1:0]            stall_cycles,
    output logic [CNT_W-1:0]            stall_events
);

    // -----------------------------------------------------------------------
    // Registered stall: feeds hold_active and the rising-edge detector.
    // It is not touched by clr_stats.
    // -----------------------------------------------------------------------
    logic stall_q;
    logic stall_d;

    assign stall_d = stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= 1'b0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign hold_active = stall_q;

    // -----------------------------------------------------------------------
    // Per-channel hold registers.
    // Priority: flush (masked) > capture when running > hold when stalled.
    // Flush applies even while stalled so a squashed value replaces the held
    // one immediately and is what the datapath sees until the stall clears.
    // -----------------------------------------------------------------------
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [WIDTH-1:0] live_c;
        logic [WIDTH-1:0] hold_q;
        logic [WIDTH-1:0] hold_d;

        assign live_c = live_in[c*WIDTH +: WIDTH];

        always_comb begin
            hold_d = hold_q;
            if (flush && FLUSH_MASK[c]) begin
                hold_d = FLUSH_VAL;
            end else if (!stall) begin
                hold_d = live_c;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                hold_q <= RESET_VAL;
            end else begin
                hold_q <= hold_d;
            end
        end

        if (MODE == MODE_REGISTERED) begin : g_reg
            // No combinational path from live_in to data_out in this mode.
            assign data_out[c*WIDTH +: WIDTH] = hold_q;
        end else begin : g_byp
            // While stalled the mux selects the hold register, so whatever the
            // memory drives on live_in (including X) does not reach the datapath.
            assign data_out[c*WIDTH +: WIDTH] = stall ? hold_q : live_c;
        end
    end

    // -----------------------------------------------------------------------
    // Stall statistics.
    // -----------------------------------------------------------------------
    logic stall_rise;

    // After reset stall_q is 0, so a stall present on the first edge counts
    // as a new event.
    assign stall_rise = stall & ~stall_q;

    sat_counter #(
        .W   (CNT_W)
    ) u_cycles_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_stats),
        .inc (stall),
        .q   (stall_cycles)
    );

    sat_counter #(
        .W   (CNT_W)
    ) u_events_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_stats),
        .inc (stall_rise),
        .q   (stall_events)
    );

endmodule : stall_hold_buffer

// File: tb/tb_stall_hold_buffer.sv
// ---------------------------------------------------------------------------
// tb_stall_hold_buffer
//   Two instances share all inputs: one in bypass mode, one registered.
//   A small reference model of the hold registers and counters produces the
//   expected outputs each cycle; they are queued and compared against both
//   instances.
// ---------------------------------------------------------------------------
module tb_stall_hold_buffer;
  import cpu_mem_pkg::*;

  localparam int          CH    = 2;
  localparam int          W     = 32;
  localparam int          CW    = 4;
  localparam logic [31:0] RVAL  = 32'h5EED_0001;
  localparam logic [31:0] FVAL  = 32'h0BAD_F00D;
  localparam logic [1:0]  FMASK = 2'b01;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           stall;
  logic           flush;
  logic           clr_stats;
  logic [CH*W-1:0] live_in;

  logic [CH*W-1:0] byp_data, reg_data;
  logic            byp_hact, reg_hact;
  logic [CW-1:0]   byp_cyc, reg_cyc, byp_ev, reg_ev;

  stall_hold_buffer #(
    .CHANNELS(CH), .WIDTH(W), .MODE(MODE_BYPASS), .RESET_VAL(RVAL),
    .FLUSH_VAL(FVAL), .FLUSH_MASK(FMASK), .CNT_W(CW)
  ) u_dut_byp (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .clr_stats(clr_stats),
    .live_in(live_in), .data_out(byp_data), .hold_active(byp_hact),
    .stall_cycles(byp_cyc), .stall_events(byp_ev)
  );

  stall_hold_buffer #(
    .CHANNELS(CH), .WIDTH(W), .MODE(MODE_REGISTERED), .RESET_VAL(RVAL),
    .FLUSH_VAL(FVAL), .FLUSH_MASK(FMASK), .CNT_W(CW)
  ) u_dut_reg (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .clr_stats(clr_stats),
    .live_in(live_in), .data_out(reg_data), .hold_active(reg_hact),
    .stall_cycles(reg_cyc), .stall_events(reg_ev)
  );

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  int n_vec = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_hold[CH];
  logic        m_stall_q;
  logic [CW-1:0] m_cyc, m_ev;

  task automatic model_reset();
    for (int c = 0; c < CH; c++) m_hold[c] = RVAL;
    m_stall_q = 1'b0;
    m_cyc     = '0;
    m_ev      = '0;
  endtask

  // Applies one rising clock edge to the model using the current inputs.
  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (flush && FMASK[c]) m_hold[c] = FVAL;
        else if (!stall)       m_hold[c] = live_in[c*W +: W];
      end
      if (clr_stats) begin
        m_cyc = '0;
        m_ev  = '0;
      end else begin
        if (stall && (m_cyc != {CW{1'b1}})) m_cyc = m_cyc + 1'b1;
        if (stall && !m_stall_q && (m_ev != {CW{1'b1}})) m_ev = m_ev + 1'b1;
      end
      m_stall_q = stall;
    end
  endtask

  // Queue the model's view of the current cycle, then pop and compare.
  task automatic check_outputs();
    logic [31:0] lv;
    for (int c = 0; c < CH; c++) begin
      lv = live_in[c*W +: W];
      exp_q.push_back({32'h0, stall ? m_hold[c] : lv});
      exp_q.push_back({32'h0, m_hold[c]});
    end
    exp_q.push_back({63'h0, m_stall_q});
    exp_q.push_back({60'h0, m_cyc});
    exp_q.push_back({60'h0, m_ev});

    for (int c = 0; c < CH; c++) begin
      check($sformatf("byp_data_ch%0d", c), {32'h0, byp_data[c*W +: W]}, exp_q.pop_front());
      check($sformatf("reg_data_ch%0d", c), {32'h0, reg_data[c*W +: W]}, exp_q.pop_front());
    end
    begin
      logic [63:0] e;
      e = exp_q.pop_front();
      check("byp_hold_active", {63'h0, byp_hact}, e);
      check("reg_hold_active", {63'h0, reg_hact}, e);
      e = exp_q.pop_front();
      check("byp_stall_cycles", {60'h0, byp_cyc}, e);
      check("reg_stall_cycles", {60'h0, reg_cyc}, e);
      e = exp_q.pop_front();
      check("byp_stall_events", {60'h0, byp_ev}, e);
      check("reg_stall_events", {60'h0, reg_ev}, e);
    end
  endtask

  // ---------------- driver ----------------
  // Entered 1 time unit after a rising edge; leaves at the same phase.
  task automatic step(input logic st, input logic fl, input logic cl, input logic [63:0] lv);
    stall     = st;
    flush     = fl;
    clr_stats = cl;
    live_in   = lv;
    #2;
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; clr_stats = 1'b0;
    live_in = {32'hCAFE_0001, 32'hCAFE_0000};
    model_reset();

    // Reset state: bypass shows live data, registered shows RESET_VAL.
    step(1'b0, 1'b0, 1'b0, {32'hCAFE_0001, 32'hCAFE_0000});
    step(1'b1, 1'b0, 1'b0, {32'hCAFE_0003, 32'hCAFE_0002});
    rst = 1'b0;

    // 1: capture AAAA/BBBB then stall three cycles while live changes.
    step(1'b0, 1'b0, 1'b0, {32'hBBBB_BBBB, 32'hAAAA_AAAA});
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, rnd64());
    check("t1_byp_frozen_ch0", {32'h0, byp_data[31:0]}, {32'h0, 32'hAAAA_AAAA});

    // 2: registered mode shows 1,2,3 one cycle late, then freezes.
    for (int i = 1; i <= 3; i++) step(1'b0, 1'b0, 1'b0, {32'(i + 100), 32'(i)});
    step(1'b1, 1'b0, 1'b0, rnd64());
    check("t2_reg_frozen_ch0", {32'h0, reg_data[31:0]}, 64'd3);
    step(1'b1, 1'b0, 1'b0, rnd64());

    // 3: flush during stall hits only channel 0.
    step(1'b0, 1'b0, 1'b0, {32'h0000_5678, 32'h0000_1234});
    step(1'b1, 1'b0, 1'b0, rnd64());
    step(1'b1, 1'b1, 1'b0, rnd64());
    step(1'b1, 1'b0, 1'b0, {32'hxxxx_xxxx, 32'hxxxx_xxxx});  // X while stalled
    check("t3_byp_flushed_ch0", {32'h0, byp_data[31:0]}, {32'h0, FVAL});
    check("t3_byp_kept_ch1", {32'h0, byp_data[63:32]}, {32'h0, 32'h0000_5678});
    step(1'b0, 1'b1, 1'b0, rnd64());  // flush while running
    step(1'b1, 1'b0, 1'b0, rnd64());
    step(1'b0, 1'b0, 1'b0, rnd64());

    // 4: bursts of 3 and 20 stall cycles with CNT_W=4.
    step(1'b0, 1'b0, 1'b1, rnd64());
    for (int i = 0; i < 3; i++)  step(1'b1, 1'b0, 1'b0, rnd64());
    step(1'b0, 1'b0, 1'b0, rnd64());
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, rnd64());
    step(1'b0, 1'b0, 1'b0, rnd64());
    check("t4_events", {60'h0, byp_ev}, 64'd2);
    check("t4_cycles_sat", {60'h0, byp_cyc}, 64'd15);
    step(1'b0, 1'b0, 1'b1, rnd64());
    step(1'b0, 1'b0, 1'b0, rnd64());

    // 5: clear coinciding with a stall rising edge.
    step(1'b0, 1'b0, 1'b0, rnd64());
    step(1'b1, 1'b0, 1'b1, rnd64());
    check("t5_clear_wins_cyc", {60'h0, reg_cyc}, 64'd0);
    step(1'b1, 1'b0, 1'b0, rnd64());
    step(1'b0, 1'b0, 1'b0, rnd64());

    // Random mix.
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 15) == 0), rnd64());

    // 6: async reset between edges during a stall.
    step(1'b0, 1'b0, 1'b0, {32'h1111_2222, 32'h3333_4444});
    step(1'b1, 1'b0, 1'b0, rnd64());
    step(1'b1, 1'b0, 1'b0, rnd64());
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    check("t6_reg_resetval", {32'h0, reg_data[31:0]}, {32'h0, RVAL});
    check("t6_hold_active", {63'h0, reg_hact}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 1'b0, 1'b0, rnd64());
    step(1'b1, 1'b0, 1'b0, rnd64());
    check("t6_event_after_reset", {60'h0, byp_ev}, 64'd1);
    step(1'b0, 1'b0, 1'b0, rnd64());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish");
    n_mis++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule : tb_stall_hold_buffer
